truth_sweep_gen: RTL and testbench
==================================

Name: truth_sweep_gen

Overview:
Parametrised, clocked exhaustive-stimulus engine for combinational lab DUTs. It drives an N-bit input vector through all 2^N combinations, in binary or Gray order, and holds each vector for a programmable dwell time. On the last cycle of each dwell it samples the DUT's single-bit output into a captured truth-table bitmap. It replaces hand-written per-vector stimulus sequences in lab benches and synthesises for board-level demonstration.

Parameters:
N_IN, 4, number of DUT inputs; legal range 1..8.
DWELL, 20, clock cycles each vector is held; legal range >= 2.
GRAY, 0, 0 = binary count order; 1 = reflected Gray order.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE or DONE
f_in  input  1  DUT output under test
vec  output  N_IN  stimulus vector to DUT
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next accepted start
table_q  output  2^N_IN  captured truth table; bit i = f_in observed while vec==i
ones_cnt  output  N_IN+1  number of 1 bits in table_q

Behaviour:
- Reset (async assert, sync release): state=IDLE, vec=0, busy=0, done=0, table_q=0, ones_cnt=0, dwell counter=0, step index=0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start=1 at edge E0 in IDLE or DONE -> RUN.
  - Same edge: table_q=0, ones_cnt=0, step=0, dwell=0, vec=map(0)=0, busy=1, done=0.
- RUN dwell:
  - Dwell counter increments each cycle 0..DWELL-1.
  - At the edge where dwell==DWELL-1: table_q[vec] <= f_in; ones_cnt += f_in; dwell <= 0.
- RUN step advance, same edge:
  - If step < 2^N_IN-1: step++, vec <= map(step+1).
  - If step == 2^N_IN-1: -> DONE, busy=0, done=1; vec holds its last value.
- Timing: table_q[map(k)] is written at edge E0+(k+1)*DWELL; done rises at E0+2^N_IN*DWELL.
- Vector mapping: GRAY=0: map(k)=k. GRAY=1: map(k)=k^(k>>1). table_q is always indexed by the actual vec value, so the final table is order-independent.
- start=1 during RUN is ignored: no restart and no effect on counters.
- DONE: all outputs hold. start=1 restarts per the acceptance rule.
- rst_n low at any point, including mid-sweep, forces reset values immediately. No partial table survives.
- Wrap-around: step never exceeds 2^N_IN-1, and vec never wraps within a sweep.
- Width rules: ones_cnt saturates naturally, because its maximum is 2^N_IN and it is N_IN+1 bits wide. The dwell counter is clog2(DWELL) bits.
- f_in is sampled only on dwell-final edges; values at other times are don't-care.

Optional Feature:
Macro SWEEP_CHECK_EN.
- Defined: adds three ports.
  - input exp_table [2^N_IN-1:0]: expected truth table, static during the sweep.
  - output mism_cnt [N_IN:0]: incremented on each sample where f_in != exp_table[vec].
  - output first_fail [N_IN-1:0]: vec of the first mismatch; valid when mism_cnt != 0.
  - Both new outputs are cleared on reset and on accepted start.
- Not defined: ports absent, no compare logic; all other behaviour identical.

Test Plan:
1. N_IN=4, DWELL=4, GRAY=0, f_in = AND of vec bits, start pulsed at E0 -> table_q=16'h8000, ones_cnt=1, done rises at E0+64, busy low from the same edge.
2. N_IN=4, DWELL=4, GRAY=0, f_in = XOR of vec bits -> table_q=16'h6996, ones_cnt=8. vec sequence 0,1,2,...,15, each held exactly 4 cycles.
3. Same as scenario 2 with GRAY=1 -> vec sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; table_q=16'h6996, ones_cnt=8.
4. Start re-pulsed at E0+10 during RUN -> ignored, done still at E0+64. rst_n pulsed low at E0+30 -> busy=0, table_q=0, vec=0 immediately. A fresh start then completes normally.
5. After done, hold start=0 for 20 cycles -> all outputs stable. Pulse start -> done=0, table_q=0 on the accepting edge.
6. SWEEP_CHECK_EN defined, exp_table=16'h6996, f_in = AND -> mism_cnt=9, first_fail=1, table_q=16'h8000.

Source files
------------

// File: rtl/truth_sweep_gen.sv
// truth_sweep_gen: exhaustive binary/Gray input sweep with per-vector dwell and truth-table capture
// Define SWEEP_CHECK_EN to add expected-table comparison (exp_table, mism_cnt, first_fail).
module truth_sweep_gen #(
  parameter int N_IN = 4,
  parameter int DWELL = 20,
  parameter int GRAY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_q,
  output logic [N_IN:0]        ones_cnt
`ifdef SWEEP_CHECK_EN
  ,
  input  logic [2**N_IN-1:0]   exp_table,
  output logic [N_IN:0]        mism_cnt,
  output logic [N_IN-1:0]      first_fail
`endif
);
  localparam int DW_W = $clog2(DWELL);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_d;
  logic [DW_W-1:0] dwell;
  logic [N_IN-1:0] step, step_nx, map_nx;
  logic accept, sample, last_step;
  always_comb begin
    accept = start && state != S_RUN;
    sample = state == S_RUN && dwell == DW_W'(DWELL - 1);
    last_step = step == {N_IN{1'b1}};
    step_nx = step + N_IN'(1);
    map_nx = GRAY != 0 ? step_nx ^ (step_nx >> 1) : step_nx;
    state_d = accept ? S_RUN : (sample && last_step) ? S_DONE : state;
  end
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      step <= '0;
      vec <= '0;
      table_q <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      dwell <= '0;
      step <= '0;
      vec <= '0;
      table_q <= '0;
      ones_cnt <= '0;
    end else if (state == S_RUN) begin
      dwell <= sample ? '0 : dwell + DW_W'(1);
      if (sample) begin
        table_q[vec] <= f_in;
        ones_cnt <= ones_cnt + (N_IN+1)'(f_in);
        // vec is left on the final vector once the sweep ends
        if (!last_step) begin
          step <= step_nx;
          vec <= map_nx;
        end
      end
    end
  end
`ifdef SWEEP_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mism_cnt <= '0;
      first_fail <= '0;
    end else if (accept) begin
      mism_cnt <= '0;
      first_fail <= '0;
    end else if (sample && f_in != exp_table[vec]) begin
      mism_cnt <= mism_cnt + (N_IN+1)'(1);
      if (mism_cnt == '0) first_fail <= vec;
    end
  end
`endif
endmodule

// File: tb/tb_truth_sweep_gen.sv
// tb_truth_sweep_gen: randomized truth-table sweeps on binary and Gray instances against a behavioural model
module tb_truth_sweep_gen;
  localparam int DW = 4;
  localparam int NV = 16;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] func = '0, exp_t = '0;
  logic [3:0] vec_b, vec_g;
  logic busy_b, busy_g, done_b, done_g, f_b, f_g;
  logic [15:0] table_b, table_g;
  logic [4:0] ones_b, ones_g;
`ifdef SWEEP_CHECK_EN
  logic [4:0] mism_b, mism_g;
  logic [3:0] ff_b, ff_g;
`endif
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign f_b = func[vec_b];
  assign f_g = func[vec_g];
  truth_sweep_gen #(.N_IN(4), .DWELL(DW), .GRAY(0)) u_bin (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_b), .vec(vec_b), .busy(busy_b),
    .done(done_b), .table_q(table_b), .ones_cnt(ones_b)
`ifdef SWEEP_CHECK_EN
    , .exp_table(exp_t), .mism_cnt(mism_b), .first_fail(ff_b)
`endif
  );
  truth_sweep_gen #(.N_IN(4), .DWELL(DW), .GRAY(1)) u_gray (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_g), .vec(vec_g), .busy(busy_g),
    .done(done_g), .table_q(table_g), .ones_cnt(ones_g)
`ifdef SWEEP_CHECK_EN
    , .exp_table(exp_t), .mism_cnt(mism_g), .first_fail(ff_g)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic int mapv(int k, int g);
    return g != 0 ? k ^ (k >> 1) : k;
  endfunction
  // table after the first s vectors of the sweep have been sampled
  function automatic int exp_tab(int s, int g, logic [15:0] f);
    int t = 0;
    for (int k = 0; k < s; k++) t |= int'(f[mapv(k, g)]) << mapv(k, g);
    return t;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_dut(string p, int g, int c, logic [3:0] v, logic b, logic d,
                           logic [15:0] t, logic [4:0] o);
    int s = c / DW > NV ? NV : c / DW;
    int et = exp_tab(s, g, func);
    chk({p, ".vec"}, 32'(v), mapv(s >= NV ? NV - 1 : s, g));
    chk({p, ".busy"}, 32'(b), 32'(s < NV));
    chk({p, ".done"}, 32'(d), 32'(s >= NV));
    chk({p, ".table"}, 32'(t), et);
    chk({p, ".ones"}, 32'(o), $countones(et));
  endtask
`ifdef SWEEP_CHECK_EN
  task automatic check_mism(string p, int g, int c, logic [4:0] m, logic [3:0] ff);
    int s = c / DW > NV ? NV : c / DW;
    int cnt = 0, first = 0;
    for (int k = 0; k < s; k++)
      if (func[mapv(k, g)] != exp_t[mapv(k, g)]) begin
        if (cnt == 0) first = mapv(k, g);
        cnt++;
      end
    chk({p, ".mism_cnt"}, 32'(m), cnt);
    if (cnt != 0) chk({p, ".first_fail"}, 32'(ff), first);
  endtask
`endif
  task automatic check_all(int c);
    check_dut("bin", 0, c, vec_b, busy_b, done_b, table_b, ones_b);
    check_dut("gray", 1, c, vec_g, busy_g, done_g, table_g, ones_g);
`ifdef SWEEP_CHECK_EN
    check_mism("bin", 0, c, mism_b, ff_b);
    check_mism("gray", 1, c, mism_g, ff_g);
`endif
  endtask
  task automatic check_reset(string p);
    chk({p, ".vec"}, 32'({vec_b, vec_g}), 0);
    chk({p, ".busy"}, 32'({busy_b, busy_g}), 0);
    chk({p, ".done"}, 32'({done_b, done_g}), 0);
    chk({p, ".table"}, {table_b, table_g}, 0);
    chk({p, ".ones"}, 32'({ones_b, ones_g}), 0);
`ifdef SWEEP_CHECK_EN
    chk({p, ".mism"}, 32'({mism_b, mism_g, ff_b, ff_g}), 0);
`endif
  endtask
  task automatic run_sweep(logic [15:0] f, logic [15:0] e, bit repulse);
    func = f;
    exp_t = e;
    start = 1;
    tick();
    start = 0;
    check_all(0);
    for (int c = 1; c <= NV * DW; c++) begin
      if (repulse && c == 10) start = 1;
      tick();
      start = 0;
      check_all(c);
    end
  endtask
  initial begin
    tick();
    tick();
    check_reset("reset");
    rst_n = 1;
    for (int i = 0; i < 3; i++) tick();
    check_reset("idle");
    run_sweep(16'h8000, 16'h6996, 0);
    for (int j = 1; j <= 20; j++) begin
      tick();
      check_all(NV * DW + j);
    end
    run_sweep(16'h6996, 16'($urandom), 1);
    for (int i = 0; i < 4; i++) run_sweep(16'($urandom), 16'($urandom), i[0]);
    func = 16'($urandom);
    exp_t = 16'($urandom);
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      check_all(c);
    end
    #3 rst_n = 0;
    #1 check_reset("async_rst");
    tick();
    check_reset("rst_held");
    rst_n = 1;
    tick();
    check_reset("post_rst");
    run_sweep(16'($urandom), 16'($urandom), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
